// File: rtl/lfsr_multi.sv
// Multi-length (8..MAX_LEN) Fibonacci LFSR pattern generator with seed load, run control
// and an optional period self-check, built only when LFSR_PERIOD_CHK_EN is defined.
module lfsr_multi #(
   parameter int MAX_LEN = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic [MAX_LEN-1:0] seed,
   input  logic [3:0]         len_sel,
   output logic [MAX_LEN-1:0] lfsr_out,
   output logic               out_valid,
   output logic               busy,
   output logic               period_done,
   output logic               period_ok,
   output logic [1:0]         o_dbg_state
);

   // Handshake: none. start/stop are level-sampled every edge; start together with stop
   // is an abort from any state. out_valid marks a cycle whose lfsr_out was freshly
   // loaded or advanced on the preceding edge.

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   localparam logic [4:0] LP_MAX_LEN = 5'(MAX_LEN);

   state_t             r_fsm;
   logic [4:0]         r_len;
   logic [MAX_LEN-1:0] r_state;
   logic               r_valid;
   logic               r_busy;

   logic [4:0]         w_len_req;
   logic [4:0]         w_len_new;
   logic [MAX_LEN-1:0] w_seed_mask;
   logic [MAX_LEN-1:0] w_seed_masked;
   logic [MAX_LEN-1:0] w_seed_eff;
   logic [MAX_LEN-1:0] w_run_mask;
   logic [15:0]        w_taps16;
   logic [MAX_LEN-1:0] w_taps;
   logic               w_fb;
   logic [MAX_LEN-1:0] w_next;
   logic               w_abort;
   logic               w_load;
   logic               w_advance;

   function automatic logic [MAX_LEN-1:0] len_mask(input logic [4:0] len);
      logic [MAX_LEN-1:0] m;
      for (int i = 0; i < MAX_LEN; i++) begin
         m[i] = (5'(i) < len);
      end
      return m;
   endfunction

   // Tap bit positions are 0-based here: tap n of the table lives in state[n-1].
   function automatic logic [15:0] tap_mask(input logic [4:0] len);
      logic [15:0] t;
      case (len)
         5'd8:    t = 16'h00B8;
         5'd9:    t = 16'h0110;
         5'd10:   t = 16'h0240;
         5'd11:   t = 16'h0500;
         5'd12:   t = 16'h0829;
         5'd13:   t = 16'h100D;
         5'd14:   t = 16'h2015;
         5'd15:   t = 16'h6000;
         5'd16:   t = 16'hD008;
         default: t = 16'h00B8;
      endcase
      return t;
   endfunction

   always_comb begin
      w_len_req     = 5'd8 + {1'b0, len_sel};
      w_len_new     = (w_len_req > LP_MAX_LEN) ? LP_MAX_LEN : w_len_req;
      w_seed_mask   = len_mask(w_len_new);
      w_seed_masked = seed & w_seed_mask;
      w_seed_eff    = (w_seed_masked == '0) ? MAX_LEN'(1) : w_seed_masked;
   end

   always_comb begin
      w_run_mask = len_mask(r_len);
      w_taps16   = tap_mask(r_len);
      w_taps     = w_taps16[MAX_LEN-1:0];
      w_fb       = ^(r_state & w_taps);
      w_next     = {r_state[MAX_LEN-2:0], w_fb} & w_run_mask;
   end

   assign w_abort   = start && stop;
   assign w_load    = (r_fsm == ST_IDLE) && start && !stop;
   assign w_advance = (r_fsm == ST_RUN) && !stop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fsm   <= ST_IDLE;
         r_len   <= 5'd8;
         r_state <= MAX_LEN'(1);
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (w_abort) begin
            r_fsm  <= ST_IDLE;
            r_busy <= 1'b0;
         end else begin
            case (r_fsm)
               ST_IDLE: begin
                  if (start) begin
                     r_fsm   <= ST_RUN;
                     r_len   <= w_len_new;
                     r_state <= w_seed_eff;
                     r_valid <= 1'b1;
                     r_busy  <= 1'b1;
                  end
               end
               ST_RUN: begin
                  if (stop) begin
                     r_fsm <= ST_PAUSE;
                  end else begin
                     r_state <= w_next;
                     r_valid <= 1'b1;
                  end
               end
               ST_PAUSE: begin
                  // Resume edge only re-enters RUN; the first advance is on the next edge.
                  if (start) begin
                     r_fsm <= ST_RUN;
                  end
               end
               default: begin
                  r_fsm  <= ST_IDLE;
                  r_busy <= 1'b0;
               end
            endcase
         end
      end
   end

   assign lfsr_out    = r_state;
   assign out_valid   = r_valid;
   assign busy        = r_busy;
   assign o_dbg_state = r_fsm;

`ifdef LFSR_PERIOD_CHK_EN
   logic [MAX_LEN-1:0] r_seed;
   logic [MAX_LEN-1:0] r_cnt;
   logic               r_pdone;
   logic               r_pok;
   logic [MAX_LEN:0]   w_cnt_inc;
   logic [MAX_LEN:0]   w_full;

   // w_full = 2^L - 1, the advance count of a maximal-length period.
   always_comb begin
      w_cnt_inc = {1'b0, r_cnt} + (MAX_LEN+1)'(1);
      for (int i = 0; i <= MAX_LEN; i++) begin
         w_full[i] = (5'(i) < r_len);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_seed  <= MAX_LEN'(1);
         r_cnt   <= '0;
         r_pdone <= 1'b0;
         r_pok   <= 1'b0;
      end else begin
         r_pdone <= 1'b0;
         r_pok   <= 1'b0;
         if (w_abort) begin
            r_cnt <= '0;
         end else if (w_load) begin
            r_seed <= w_seed_eff;
            r_cnt  <= '0;
         end else if (w_advance) begin
            if (w_next == r_seed) begin
               r_pdone <= 1'b1;
               r_pok   <= (w_cnt_inc == w_full);
               r_cnt   <= '0;
            end else if (r_cnt != '1) begin
               r_cnt <= w_cnt_inc[MAX_LEN-1:0];
            end
         end
      end
   end

   assign period_done = r_pdone;
   assign period_ok   = r_pok;
`else
   assign period_done = 1'b0;
   assign period_ok   = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_multi.sv
// Directed, table-driven bench for lfsr_multi (MAX_LEN = 16); period checks adapt to
// whether LFSR_PERIOD_CHK_EN is defined.
module tb_lfsr_multi;

   logic        clk;
   logic        rst;
   logic        start;
   logic        stop;
   logic [15:0] seed;
   logic [3:0]  len_sel;
   logic [15:0] lfsr_out;
   logic        out_valid;
   logic        busy;
   logic        period_done;
   logic        period_ok;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   lfsr_multi #(.MAX_LEN(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .seed        (seed),
      .len_sel     (len_sel),
      .lfsr_out    (lfsr_out),
      .out_valid   (out_valid),
      .busy        (busy),
      .period_done (period_done),
      .period_ok   (period_ok),
      .o_dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        s;
      logic        p;
      logic [3:0]  l;
      logic [15:0] sd;
      logic [15:0] eo;
      logic        ev;
      logic        eb;
      logic [1:0]  est;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive inputs, take one rising edge, then settle 1 ns before the caller samples.
   task automatic step(input logic s, input logic p, input logic [3:0] l, input logic [15:0] sd);
      start   = s;
      stop    = p;
      len_sel = l;
      seed    = sd;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic s, input logic p, input logic [3:0] l, input logic [15:0] sd,
                      input logic [15:0] eo, input logic ev, input logic eb, input logic [1:0] est);
      vec_t v;
      v.s = s; v.p = p; v.l = l; v.sd = sd; v.eo = eo; v.ev = ev; v.eb = eb; v.est = est;
      tbl.push_back(v);
   endtask

   task automatic run_period(input logic [3:0] l, input logic [15:0] sd, input int exp_adv,
                             input int reps);
      int   k;
      logic hit;
      step(1'b1, 1'b0, l, sd);
      check("period_start_out", lfsr_out, sd);
      for (int r = 0; r < reps; r++) begin
         hit = 1'b0;
         k   = 0;
`ifdef LFSR_PERIOD_CHK_EN
         while (!hit && k < exp_adv + 8) begin
            step(1'b0, 1'b0, l, sd);
            k++;
            if (period_done) hit = 1'b1;
         end
         check("period_hit", 32'(hit), 32'd1);
         check("period_adv", k, exp_adv);
         check("period_ok", 32'(period_ok), 32'd1);
         check("period_out", lfsr_out, sd);
`else
         for (int c = 0; c < exp_adv + 8; c++) begin
            step(1'b0, 1'b0, l, sd);
            if (period_done || period_ok) hit = 1'b1;
         end
         check("no_period_pulse", 32'(hit), 32'd0);
`endif
      end
      step(1'b1, 1'b1, l, sd);
      check("period_abort_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; seed = '0; len_sel = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_out", lfsr_out, 32'h1);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pdone", 32'(period_done), 32'd0);
      check("rst_pok", 32'(period_ok), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);

      //   s     p     len   seed      out       vld   busy  fsm
      add(1'b1, 1'b0, 4'd0, 16'h0001, 16'h0001, 1'b1, 1'b1, 2'd1);
      add(1'b0, 1'b0, 4'd0, 16'h0001, 16'h0002, 1'b1, 1'b1, 2'd1);
      add(1'b0, 1'b0, 4'd0, 16'h0001, 16'h0004, 1'b1, 1'b1, 2'd1);
      add(1'b0, 1'b0, 4'd0, 16'h0001, 16'h0008, 1'b1, 1'b1, 2'd1);
      add(1'b0, 1'b0, 4'd0, 16'h0001, 16'h0011, 1'b1, 1'b1, 2'd1);
      add(1'b0, 1'b0, 4'd0, 16'h0001, 16'h0023, 1'b1, 1'b1, 2'd1);
      add(1'b0, 1'b1, 4'd0, 16'h0001, 16'h0023, 1'b0, 1'b1, 2'd2);
      add(1'b0, 1'b1, 4'd0, 16'h0001, 16'h0023, 1'b0, 1'b1, 2'd2);
      add(1'b0, 1'b0, 4'd5, 16'h0001, 16'h0023, 1'b0, 1'b1, 2'd2);
      add(1'b1, 1'b0, 4'd5, 16'h0001, 16'h0023, 1'b0, 1'b1, 2'd1);
      add(1'b0, 1'b0, 4'd5, 16'h0001, 16'h0047, 1'b1, 1'b1, 2'd1);
      add(1'b0, 1'b0, 4'd5, 16'h0001, 16'h008E, 1'b1, 1'b1, 2'd1);
      add(1'b0, 1'b0, 4'd5, 16'h0001, 16'h001C, 1'b1, 1'b1, 2'd1);
      add(1'b1, 1'b1, 4'd0, 16'h0001, 16'h001C, 1'b0, 1'b0, 2'd0);
      add(1'b0, 1'b1, 4'd0, 16'h0001, 16'h001C, 1'b0, 1'b0, 2'd0);
      add(1'b1, 1'b0, 4'd0, 16'h0000, 16'h0001, 1'b1, 1'b1, 2'd1);
      add(1'b0, 1'b0, 4'd0, 16'h0000, 16'h0002, 1'b1, 1'b1, 2'd1);
      add(1'b1, 1'b1, 4'd0, 16'h0000, 16'h0002, 1'b0, 1'b0, 2'd0);
      add(1'b1, 1'b0, 4'd0, 16'hFF00, 16'h0001, 1'b1, 1'b1, 2'd1);
      add(1'b1, 1'b1, 4'd0, 16'hFF00, 16'h0001, 1'b0, 1'b0, 2'd0);
      add(1'b1, 1'b0, 4'd15, 16'h8000, 16'h8000, 1'b1, 1'b1, 2'd1);
      add(1'b0, 1'b0, 4'd15, 16'h8000, 16'h0001, 1'b1, 1'b1, 2'd1);
      add(1'b1, 1'b1, 4'd15, 16'h8000, 16'h0001, 1'b0, 1'b0, 2'd0);
      add(1'b1, 1'b0, 4'd1, 16'hFFFF, 16'h01FF, 1'b1, 1'b1, 2'd1);
      add(1'b0, 1'b0, 4'd1, 16'hFFFF, 16'h01FE, 1'b1, 1'b1, 2'd1);
      add(1'b1, 1'b1, 4'd1, 16'hFFFF, 16'h01FE, 1'b0, 1'b0, 2'd0);
      add(1'b1, 1'b0, 4'd4, 16'h0801, 16'h0801, 1'b1, 1'b1, 2'd1);
      add(1'b0, 1'b0, 4'd4, 16'h0801, 16'h0002, 1'b1, 1'b1, 2'd1);
      add(1'b0, 1'b1, 4'd4, 16'h0801, 16'h0002, 1'b0, 1'b1, 2'd2);
      add(1'b1, 1'b1, 4'd4, 16'h0801, 16'h0002, 1'b0, 1'b0, 2'd0);

      foreach (tbl[i]) begin
         step(tbl[i].s, tbl[i].p, tbl[i].l, tbl[i].sd);
         check($sformatf("vec%0d_out", i), lfsr_out, tbl[i].eo);
         check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
         check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].eb));
         check($sformatf("vec%0d_state", i), 32'(dbg_state), 32'(tbl[i].est));
         check($sformatf("vec%0d_pdone", i), 32'(period_done), 32'd0);
      end

      // Reset on the edge that would complete the first L=8 period: no pulse may escape.
      step(1'b1, 1'b0, 4'd0, 16'h0001);
      for (int c = 0; c < 254; c++) step(1'b0, 1'b0, 4'd0, 16'h0001);
      rst = 1'b1;
      step(1'b0, 1'b0, 4'd0, 16'h0001);
      rst = 1'b0;
      check("midrst_out", lfsr_out, 32'h1);
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_pdone", 32'(period_done), 32'd0);
      check("midrst_pok", 32'(period_ok), 32'd0);
      check("midrst_state", 32'(dbg_state), 32'd0);
      step(1'b0, 1'b0, 4'd0, 16'h0001);
      check("midrst_hold_out", lfsr_out, 32'h1);
      check("midrst_hold_pdone", 32'(period_done), 32'd0);

      run_period(4'd0, 16'h0001, 255, 2);
      run_period(4'd1, 16'h0001, 511, 2);
      run_period(4'd15, 16'h0001, 65535, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
